// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : ASCII codes and writer state encoding for the number overlay path
// Revision: 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam logic [6:0] ASCII_ZERO  = 7'h30;
  localparam logic [6:0] ASCII_NINE  = 7'h39;
  localparam logic [6:0] ASCII_SPACE = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } score_wr_state_t;

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bin_to_bcd_seq : iterative double-dabble converter, one input bit per clock
// Revision: 1.0
// ----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH  = 7,
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic                    finished
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     left_q, left_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    shift_d = shift_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    left_d  = left_q;

    if (start) begin
      // The first step runs on the load edge: an all-zero BCD needs no adjust.
      shift_d = bin_in << 1;
      bcd_d   = BCD_W'(bin_in[BIN_WIDTH-1]);
      ovf_d   = 1'b0;
      left_d  = CNT_W'(BIN_WIDTH - 1);
    end else if (left_q != '0) begin
      shift_d = shift_q << 1;
      bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
      ovf_d   = ovf_q | bcd_adj[BCD_W-1];
      left_d  = left_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      left_q  <= '0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      left_q  <= left_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign finished = (left_q == '0);

endmodule
`default_nettype wire

// File: rtl/score_text_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// score_text_writer : binary value -> decimal ASCII digits into the char RAM.
// Optional SCORE_LEADING_ZERO_BLANK_EN writes leading zeros as spaces. Rev 1.0
// ----------------------------------------------------------------------------
module score_text_writer
  import vga_pkg::*;
#(
  parameter int BIN_WIDTH  = 7,
  parameter int NUM_DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          req_valid,
  input  logic [BIN_WIDTH-1:0]          bin_number,
  output logic                          req_ready,
  output logic                          wr_en,
  output logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  output logic [6:0]                    wr_data,
  output logic                          busy,
  output logic                          done
);

  localparam int ADDR_W = $clog2(NUM_DIGITS);
  localparam int BCD_W  = 4 * NUM_DIGITS;

  score_wr_state_t   state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, next_addr;
  logic [6:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              conv_start;
  logic [BCD_W-1:0]  bcd;
  logic              bcd_overflow;
  logic              bcd_finished;
  logic [6:0]        char_arr [NUM_DIGITS];

  bin_to_bcd_seq #(
    .BIN_WIDTH  (BIN_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (conv_start),
    .bin_in   (bin_number),
    .bcd_out  (bcd),
    .overflow (bcd_overflow),
    .finished (bcd_finished)
  );

  // char_arr[0] is the most significant digit, matching char RAM address 0.
  always_comb begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic lead_zero;
    lead_zero = 1'b1;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      lead_zero = lead_zero & (bcd[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
`endif
      if (bcd_overflow) begin
        char_arr[k] = ASCII_NINE;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      end else if (lead_zero && (k != NUM_DIGITS - 1)) begin
        char_arr[k] = ASCII_SPACE;
`endif
      end else begin
        char_arr[k] = ASCII_ZERO + {3'b000, bcd[4*(NUM_DIGITS-1-k) +: 4]};
      end
    end
  end

  // Outputs are computed for the state being entered, so they line up with it.
  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    conv_start  = 1'b0;
    next_addr   = wr_addr_q + ADDR_W'(1);

    if (!enable) begin
      state_d   = ST_IDLE;
      wr_addr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            conv_start = 1'b1;
            state_d    = ST_CONVERT;
            busy_d     = 1'b1;
          end else begin
            req_ready_d = 1'b1;
          end
        end
        ST_CONVERT: begin
          busy_d = 1'b1;
          if (bcd_finished) begin
            state_d   = ST_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = char_arr[0];
          end
        end
        ST_WRITE: begin
          if (wr_addr_q == ADDR_W'(NUM_DIGITS - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = next_addr;
            wr_data_d = char_arr[next_addr];
          end
        end
        ST_DONE: begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_score_text_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_score_text_writer : directed bench with a write scoreboard for the writer
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_score_text_writer;

  localparam int BW      = 7;
  localparam int ND      = 2;
  localparam int MAX_VAL = 99;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       req_valid;
  logic [6:0] bin_number;
  logic       req_ready;
  logic       wr_en;
  logic [0:0] wr_addr;
  logic [6:0] wr_data;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [0:0] addr;
    logic [6:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  accept_cnt = 0;
  int  last_accept_cyc = 0;
  int  done_cnt = 0;
  int  last_done_cyc = 0;
  int  prev_done_cyc = 0;
  int  wr_cnt = 0;

  score_text_writer #(
    .BIN_WIDTH  (BW),
    .NUM_DIGITS (ND)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req_valid  (req_valid),
    .bin_number (bin_number),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference digits via div/mod, most significant first.
  task automatic push_expect(input int v);
    int         dig[ND];
    int         t;
    logic [6:0] ch;
    wr_t        e;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    bit         lead;
    lead = 1'b1;
`endif
    t = v;
    for (int k = ND - 1; k >= 0; k--) begin
      dig[k] = t % 10;
      t      = t / 10;
    end
    for (int k = 0; k < ND; k++) begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      lead = lead && (dig[k] == 0);
`endif
      if (v > MAX_VAL) ch = 7'h39;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      else if (lead && (k != ND - 1)) ch = 7'h20;
`endif
      else ch = 7'h30 + 7'(dig[k]);
      e.addr = 1'(k);
      e.data = ch;
      exp_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Accept monitor: scoreboard entries are queued on the accepting edge.
  initial forever begin
    @(posedge clk);
    if (rst && enable && req_valid && req_ready) begin
      accept_cnt++;
      last_accept_cyc = cyc;
      push_expect(int'(bin_number));
    end
  end

  // Output monitor: pops expected writes, records done pulses.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (rst && wr_en) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr_data", {24'd0, wr_addr, wr_data}, {24'd0, e.addr, e.data});
      end
    end
    if (rst && done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      check("ready_low_in_done", 32'(req_ready), 32'd0);
      check("wr_en_low_in_done", 32'(wr_en), 32'd0);
    end
  end

  task automatic do_req(input int v);
    @(negedge clk);
    bin_number = 7'(v);
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_low_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int vals[5];
    int d0, w0, a0, n;
    vals = '{42, 127, 99, 5, 0};
    rst        = 1'b1;
    enable     = 1'b1;
    req_valid  = 1'b0;
    bin_number = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {20'd0, req_ready, wr_en, wr_addr, wr_data, busy, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Directed conversions: normal, saturated, max exact, small, zero.
    foreach (vals[i]) begin
      d0 = done_cnt;
      do_req(vals[i]);
      wait_done("done_seen", d0 + 1);
      check("latency", 32'(last_done_cyc - last_accept_cyc), 32'd10);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("overflow_flag", 32'(dut.u_bcd.overflow), 32'(vals[i] > MAX_VAL));
    end

    // Abort during CONVERT.
    @(negedge clk);
    d0 = done_cnt;
    w0 = wr_cnt;
    do_req(77);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_ready_low", 32'(req_ready), 32'd0);
    repeat (15) @(negedge clk);
    check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("disabled_ready_low", 32'(req_ready), 32'd0);
    exp_q.delete();
    enable = 1'b1;
    @(negedge clk);
    check("ready_after_enable", 32'(req_ready), 32'd1);

    // req_valid held high: one accept per IDLE visit, done pulses 11 apart.
    a0 = accept_cnt;
    d0 = done_cnt;
    bin_number = 7'd10;
    req_valid  = 1'b1;
    n = 0;
    while (accept_cnt < a0 + 1 && n < 10) begin @(negedge clk); n++; end
    bin_number = 7'd11;
    n = 0;
    while (accept_cnt < a0 + 2 && n < 30) begin @(negedge clk); n++; end
    req_valid = 1'b0;
    wait_done("b2b_done_seen", d0 + 2);
    check("b2b_done_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd11);
    repeat (15) @(negedge clk);
    check("b2b_accept_count", 32'(accept_cnt - a0), 32'd2);
    check("b2b_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of WRITE.
    w0 = wr_cnt;
    do_req(42);
    n = 0;
    while (wr_cnt == w0 && n < 20) begin @(negedge clk); n++; end
    check("midwrite_reached", 32'(wr_cnt != w0), 32'd1);
    rst = 1'b0;
    #1;
    check("midwrite_reset_outputs", {20'd0, req_ready, wr_en, wr_addr, wr_data, busy, done}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_midwrite_reset", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
